// File: rtl/updown_pkg.sv
// Shared types and default sizes for the up/down sweep controller.
// The DWELL state exists only when UPDOWN_SWEEP_DWELL_EN is defined.
package updown_pkg;

  localparam int UPD_WIDTH_DEF  = 4;
  localparam int UPD_PASS_W_DEF = 8;

`ifdef UPDOWN_SWEEP_DWELL_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UP    = 2'd1,
    ST_DOWN  = 2'd2,
    ST_DWELL = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/updown_count_sync.sv
// Loadable up/down counter with synchronous active-high reset.
// Load beats enable; the controller guarantees no stepping past its bounds.
module updown_count_sync
  import updown_pkg::*;
#(
  parameter int WIDTH = UPD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en) begin
      r_count <= up_down ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
    end
  end

  assign count = r_count;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweeps a counter lo->hi->lo for a programmable number of passes.
// Optional hold at hi is enabled by defining UPDOWN_SWEEP_DWELL_EN.
module updown_sweep_ctrl
  import updown_pkg::*;
#(
  parameter int WIDTH     = UPD_WIDTH_DEF,
  parameter int PASS_W    = UPD_PASS_W_DEF,
  parameter int DWELL_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [PASS_W-1:0] passes,
  input  logic              step_en,
  input  logic              abort,
  output logic [WIDTH-1:0]  count,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic              range_err
);

  state_t            r_state;
  logic [PASS_W-1:0] r_rem;
  logic [WIDTH-1:0]  r_lo;
  logic [WIDTH-1:0]  r_hi;
  logic              r_dir;
  logic              r_busy;
  logic              r_done;
  logic              r_range_err;

  logic [WIDTH-1:0]  w_count;
  logic              w_load;
  logic              w_en;
  logic              w_up;
  logic              w_start_ok;
  logic              w_step;

  assign w_start_ok = start && (lo < hi) && (passes != '0);
  assign w_step     = step_en && !abort;

`ifdef UPDOWN_SWEEP_DWELL_EN
  localparam int DW_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  logic [DW_W-1:0] r_dwell;
  logic            w_dwell_last;
  assign w_dwell_last = (r_dwell == DW_W'(DWELL_CYC - 1));
`endif

  // Counter steering: decisions use the latched bounds, the load uses live lo
  always_comb begin
    w_load = 1'b0;
    w_en   = 1'b0;
    w_up   = 1'b1;
    case (r_state)
      ST_IDLE: w_load = w_start_ok;
      ST_UP: begin
        if (w_step) begin
          if (w_count != r_hi) begin
            w_en = 1'b1;
          end else begin
`ifndef UPDOWN_SWEEP_DWELL_EN
            w_en = 1'b1;
            w_up = 1'b0;
`endif
          end
        end
      end
      ST_DOWN: begin
        if (w_step) begin
          if (w_count != r_lo) begin
            w_en = 1'b1;
            w_up = 1'b0;
          end else if (r_rem > PASS_W'(1)) begin
            w_en = 1'b1;
          end
        end
      end
`ifdef UPDOWN_SWEEP_DWELL_EN
      ST_DWELL: begin
        if (w_step && w_dwell_last) begin
          w_en = 1'b1;
          w_up = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  updown_count_sync #(.WIDTH(WIDTH)) u_count (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (lo),
    .en       (w_en),
    .up_down  (w_up),
    .count    (w_count)
  );

  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && w_start_ok) begin
      r_lo <= lo;
      r_hi <= hi;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_dir       <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_range_err <= 1'b0;
`ifdef UPDOWN_SWEEP_DWELL_EN
      r_dwell     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (lo >= hi) begin
              r_done      <= 1'b1;
              r_range_err <= 1'b1;
            end else if (passes == '0) begin
              r_done      <= 1'b1;
              r_range_err <= 1'b0;
            end else begin
              r_state     <= ST_UP;
              r_busy      <= 1'b1;
              r_dir       <= 1'b1;
              r_rem       <= passes;
              r_range_err <= 1'b0;
            end
          end
        end
        ST_UP: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (step_en && w_count == r_hi) begin
`ifdef UPDOWN_SWEEP_DWELL_EN
            r_state <= ST_DWELL;
            r_dwell <= '0;
`else
            r_state <= ST_DOWN;
            r_dir   <= 1'b0;
`endif
          end
        end
        ST_DOWN: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (step_en && w_count == r_lo) begin
            if (r_rem > PASS_W'(1)) begin
              r_rem   <= r_rem - PASS_W'(1);
              r_state <= ST_UP;
              r_dir   <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
`ifdef UPDOWN_SWEEP_DWELL_EN
        ST_DWELL: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (step_en) begin
            if (w_dwell_last) begin
              r_state <= ST_DOWN;
              r_dir   <= 1'b0;
            end else begin
              r_dwell <= r_dwell + DW_W'(1);
            end
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign count     = w_count;
  assign dir       = r_dir;
  assign busy      = r_busy;
  assign done      = r_done;
  assign range_err = r_range_err;

endmodule
